// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: FSM encoding,
// default parameter values and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 8;
    localparam int DEF_PARITY_EN  = 0;
    localparam int DEF_PARITY_ODD = 0;
    localparam int DEF_FIFO_DEPTH = 4;

    // Data is zero-extended to 8 bits by the caller, which leaves the XOR unchanged.
    function automatic logic parity_of(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: circular buffer with pointers one bit wider than the address,
// head word presented combinationally from registered storage.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wp;
    logic [AW:0]      r_rp;
    logic             w_wr;
    logic             w_rd;

    assign level = r_wp - r_rp;
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (r_wp == r_rp);
    assign dout  = r_mem[r_rp[AW-1:0]];

    // A push into a full FIFO only lands when the head is leaving in the same cycle.
    assign w_wr = push & (~full | pop);
    assign w_rd = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wp[AW-1:0]] <= din;
                r_wp                <= r_wp + 1'b1;
            end
            if (w_rd) r_rp <= r_rp + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, oversampled FSM with
// 3-sample majority vote, optional parity, receive FIFO and sticky errors.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int PARITY_EN  = DEF_PARITY_EN,
    parameter int PARITY_ODD = DEF_PARITY_ODD,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en_rx,
    input  logic                          rxd,
    input  logic                          rd,
    output logic [DATA_BITS-1:0]          d_out,
    output logic                          rs,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          err_clr
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] C_PRE  = CW'(OVERSAMPLE/2 - 1);
    localparam logic [CW-1:0] C_MID  = CW'(OVERSAMPLE/2);
    localparam logic [CW-1:0] C_DEC  = CW'(OVERSAMPLE/2 + 1);
    localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);

    rx_state_t          r_state, w_nxt;
    logic [1:0]         r_sync;
    logic [CW-1:0]      r_cnt;
    logic [BW-1:0]      r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic               r_v0, r_v1, r_pbad;
    logic               r_perr, r_ferr, r_ovr;

    logic               w_rxs, w_vote, w_dec, w_wrap;
    logic               w_push, w_ferr_set, w_ovr_set;
    logic               w_full, w_empty;
    logic [7:0]         w_data8;

    assign w_rxs   = r_sync[1];
    assign w_vote  = (r_v0 & r_v1) | (r_v0 & w_rxs) | (r_v1 & w_rxs);
    assign w_dec   = en_rx && (r_cnt == C_DEC);
    assign w_wrap  = en_rx && (r_cnt == C_LAST);
    assign w_data8 = 8'(r_shift);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= 2'b11;
        else     r_sync <= {r_sync[0], rxd};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nxt;
    end

    always_comb begin
        w_nxt      = r_state;
        w_push     = 1'b0;
        w_ferr_set = 1'b0;
        case (r_state)
            IDLE:      if (en_rx && !w_rxs) w_nxt = START;
            START:     if (w_dec && w_vote) w_nxt = IDLE;
                       else if (w_wrap)     w_nxt = DATA;
            DATA:      if (w_wrap && r_bit == BW'(DATA_BITS-1))
                           w_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:    if (w_wrap) w_nxt = STOP;
            STOP:      if (w_dec) begin
                           if (w_vote) begin
                               w_push = 1'b1;
                               w_nxt  = IDLE;
                           end else begin
                               w_ferr_set = 1'b1;
                               w_nxt      = WAIT_IDLE;
                           end
                       end
            WAIT_IDLE: if (en_rx && w_rxs) w_nxt = IDLE;
            default:   w_nxt = IDLE;
        endcase
    end

    // The tick that detects the falling edge is tick 0, so the counter restarts at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_v0    <= 1'b1;
            r_v1    <= 1'b1;
            r_pbad  <= 1'b0;
        end else if (en_rx) begin
            r_cnt <= (r_state == IDLE) ? CW'(1) : r_cnt + CW'(1);
            if (r_cnt == C_PRE) r_v0 <= w_rxs;
            if (r_cnt == C_MID) r_v1 <= w_rxs;
            if (r_state == START) begin
                r_bit  <= '0;
                r_pbad <= 1'b0;
            end
            if (r_state == DATA && r_cnt == C_DEC)  r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
            if (r_state == DATA && r_cnt == C_LAST) r_bit   <= r_bit + 1'b1;
            if (r_state == PARITY && r_cnt == C_DEC)
                r_pbad <= w_vote ^ parity_of(w_data8, 1'(PARITY_ODD));
        end
    end

    assign w_ovr_set = w_push & w_full & ~rd;

    // Setting a flag wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            r_perr <= (w_push & r_pbad) | (r_perr & ~err_clr);
            r_ferr <= w_ferr_set        | (r_ferr & ~err_clr);
            r_ovr  <= w_ovr_set         | (r_ovr  & ~err_clr);
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (rd),
        .din   (r_shift),
        .dout  (d_out),
        .level (level),
        .full  (w_full),
        .empty (w_empty)
    );

    assign rs         = ~w_empty;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign overrun    = r_ovr;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: one default instance (8N1, depth 4)
// and one even-parity instance; a negedge monitor checks every popped word.
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_rx = 1'b0;
    logic       err_clr = 1'b0;
    logic       rxd_a = 1'b1, rxd_b = 1'b1;
    logic       rd_a = 1'b0, rd_b = 1'b0;
    logic [7:0] d_out_a, d_out_b;
    logic       rs_a, rs_b;
    logic [2:0] level_a, level_b;
    logic       perr_a, ferr_a, ovr_a;
    logic       perr_b, ferr_b, ovr_b;

    int n_tot = 0;
    int n_pass = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    always #5 clk = ~clk;

    uart_rx_param u_a (
        .clk(clk), .rst(rst), .en_rx(en_rx), .rxd(rxd_a), .rd(rd_a),
        .d_out(d_out_a), .rs(rs_a), .level(level_a),
        .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a), .err_clr(err_clr)
    );

    uart_rx_param #(.PARITY_EN(1), .PARITY_ODD(0)) u_b (
        .clk(clk), .rst(rst), .en_rx(en_rx), .rxd(rxd_b), .rd(rd_b),
        .d_out(d_out_b), .rs(rs_b), .level(level_b),
        .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b), .err_clr(err_clr)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Monitor: every accepted pop is compared against the scoreboard head.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rd_a && rs_a) begin
            if (qa.size() == 0) begin
                n_tot++;
                $display("FAIL pop_a: got %0h expected nothing", d_out_a);
            end else begin
                e = qa.pop_front();
                chk("pop_a", 32'(d_out_a), 32'(e));
            end
        end
        if (rd_b && rs_b) begin
            if (qb.size() == 0) begin
                n_tot++;
                $display("FAIL pop_b: got %0h expected nothing", d_out_b);
            end else begin
                e = qb.pop_front();
                chk("pop_b", 32'(d_out_b), 32'(e));
            end
        end
    end

    task automatic tick(input bit r, input bit which);
        repeat (2) begin @(posedge clk); #1; end
        en_rx = 1'b1;
        if (r) begin
            if (which) rd_b = 1'b1;
            else       rd_a = 1'b1;
        end
        @(posedge clk); #1;
        en_rx = 1'b0;
        rd_a  = 1'b0;
        rd_b  = 1'b0;
    endtask

    task automatic set_rxd(input bit which, input logic v);
        if (which) rxd_b = v;
        else       rxd_a = v;
    endtask

    task automatic ticks(input bit which, input logic v, input int n);
        set_rxd(which, v);
        for (int k = 0; k < n; k++) tick(1'b0, which);
    endtask

    task automatic send(input bit which, input logic [7:0] d, input bit par, input logic pbit,
                        input logic stop, input int glitch, input bit rd_push, input bit chk_edge);
        logic [10:0] fr;
        int          n;
        logic        b;
        if (par) begin fr = {stop, pbit, d, 1'b0};        n = 11; end
        else     begin fr = {1'b0, stop, d, 1'b0};        n = 10; end
        for (int i = 0; i < n; i++) begin
            for (int t = 0; t < 8; t++) begin
                b = fr[i];
                if (i == glitch && t == 4) b = ~b;
                set_rxd(which, b);
                tick(rd_push && i == n-1 && t == 5, which);
                if (chk_edge && i == n-1 && t == 4) chk("rs_before_stop_dec", 32'(rs_a), 32'd0);
                if (chk_edge && i == n-1 && t == 5) chk("rs_at_stop_dec", 32'(rs_a), 32'd1);
            end
        end
    endtask

    task automatic drain(input bit which);
        for (int k = 0; k < 8; k++) begin
            if (which ? rs_b : rs_a) begin
                if (which) rd_b = 1'b1;
                else       rd_a = 1'b1;
                @(posedge clk); #1;
                rd_a = 1'b0;
                rd_b = 1'b0;
            end
        end
    endtask

    task automatic clr_err();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_rs", 32'(rs_a), 32'd0);
        chk("reset_level", 32'(level_a), 32'd0);
        chk("reset_dout", 32'(d_out_a), 32'd0);
        chk("reset_flags", 32'({perr_a, ferr_a, ovr_a}), 32'd0);

        // Basic frame with push-edge timing
        qa.push_back(8'h55);
        send(0, 8'h55, 0, 0, 1, -1, 0, 1);
        chk("t1_level", 32'(level_a), 32'd1);
        chk("t1_dout", 32'(d_out_a), 32'h55);
        chk("t1_flags", 32'({perr_a, ferr_a, ovr_a}), 32'd0);
        drain(0);
        chk("t1_rs_after_rd", 32'(rs_a), 32'd0);

        // Start-bit glitch, then an in-bit glitch outvoted
        ticks(0, 1'b0, 2);
        ticks(0, 1'b1, 10);
        chk("t2_no_push", 32'(level_a), 32'd0);
        chk("t2_no_flags", 32'({perr_a, ferr_a, ovr_a}), 32'd0);
        qa.push_back(8'hA3);
        send(0, 8'hA3, 0, 0, 1, 3, 0, 0);
        chk("t2_glitch_level", 32'(level_a), 32'd1);
        drain(0);

        // Even parity: 0x07 needs parity bit 1
        qb.push_back(8'h07);
        send(1, 8'h07, 1, 1'b0, 1, -1, 0, 0);
        chk("t3_perr_set", 32'(perr_b), 32'd1);
        chk("t3_bad_word_pushed", 32'(level_b), 32'd1);
        clr_err();
        chk("t3_perr_clr", 32'(perr_b), 32'd0);
        qb.push_back(8'h07);
        send(1, 8'h07, 1, 1'b1, 1, -1, 0, 0);
        chk("t3_perr_good", 32'(perr_b), 32'd0);
        chk("t3_level2", 32'(level_b), 32'd2);
        drain(1);

        // Framing error, line held low, then recovery
        send(0, 8'h3C, 0, 0, 0, -1, 0, 0);
        ticks(0, 1'b0, 16);
        chk("t4_no_push", 32'(level_a), 32'd0);
        chk("t4_ferr", 32'(ferr_a), 32'd1);
        ticks(0, 1'b1, 4);
        qa.push_back(8'h81);
        send(0, 8'h81, 0, 0, 1, -1, 0, 0);
        chk("t4_recovered", 32'(level_a), 32'd1);
        drain(0);
        chk("t4_ferr_sticky", 32'(ferr_a), 32'd1);
        clr_err();
        chk("t4_ferr_clr", 32'(ferr_a), 32'd0);

        // Overrun: fifth word dropped
        for (int k = 1; k <= 4; k++) qa.push_back(8'(k));
        for (int k = 1; k <= 5; k++) send(0, 8'(k), 0, 0, 1, -1, 0, 0);
        chk("t5_level_full", 32'(level_a), 32'd4);
        chk("t5_overrun", 32'(ovr_a), 32'd1);
        drain(0);
        clr_err();
        chk("t5_ovr_clr", 32'(ovr_a), 32'd0);
        // Pop on the push edge of the fifth word: no loss
        for (int k = 1; k <= 5; k++) qa.push_back(8'(k));
        for (int k = 1; k <= 4; k++) send(0, 8'(k), 0, 0, 1, -1, 0, 0);
        send(0, 8'h05, 0, 0, 1, -1, 1, 0);
        chk("t5b_no_overrun", 32'(ovr_a), 32'd0);
        chk("t5b_level", 32'(level_a), 32'd4);
        chk("t5b_head", 32'(d_out_a), 32'h02);
        drain(0);
        rd_a = 1'b1; @(posedge clk); #1; rd_a = 1'b0;
        chk("t5_rd_empty", 32'(level_a), 32'd0);

        // Reset mid-frame with a word still queued
        send(0, 8'h99, 0, 0, 1, -1, 0, 0);
        chk("t6_pre_level", 32'(level_a), 32'd1);
        ticks(0, 1'b0, 8);
        ticks(0, 1'b1, 24);
        rst = 1'b1;
        #1;
        chk("t6_rst_rs", 32'(rs_a), 32'd0);
        chk("t6_rst_level", 32'(level_a), 32'd0);
        chk("t6_rst_dout", 32'(d_out_a), 32'd0);
        chk("t6_rst_flags", 32'({perr_a, ferr_a, ovr_a}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        ticks(0, 1'b1, 2);
        qa.push_back(8'h12);
        send(0, 8'h12, 0, 0, 1, -1, 0, 0);
        chk("t6_level", 32'(level_a), 32'd1);
        chk("t6_flags", 32'({perr_a, ferr_a, ovr_a}), 32'd0);
        drain(0);

        chk("qa_empty", 32'(qa.size()), 32'd0);
        chk("qb_empty", 32'(qb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receive unit in the MiniUart. Adds configurable data width, oversampling ratio, optional parity, 3-sample majority voting, a receive FIFO, and sticky error flags (parity, framing, overrun). Sits between the pad-level RxD line and the CPU-side UART register interface.

Parameters:
DATA_BITS, 8: data bits per frame, legal range 5..8.
OVERSAMPLE, 8: en_rx ticks per bit; power of two, at least 8.
PARITY_EN, 0: 1 means a parity bit follows the data bits.
PARITY_ODD, 0: 1 selects odd parity, 0 selects even; ignored when PARITY_EN=0.
FIFO_DEPTH, 4: receive FIFO entries; power of two, at least 2.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
en_rx  in  1  oversample tick, one clk wide, at OVERSAMPLE x baud
rxd  in  1  serial input, asynchronous to clk
rd  in  1  pop strobe, one clk wide
d_out  out  DATA_BITS  FIFO head word
rs  out  1  receive status; 1 when FIFO is non-empty
level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
parity_err  out  1  sticky parity error
frame_err  out  1  sticky framing error
overrun  out  1  sticky overrun
err_clr  in  1  clears all three sticky flags

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE; sample and bit counters clear.
  - FIFO empties, so rs=0 and level=0.
  - d_out=0; all error flags are 0.
  - Synchroniser flops are preset to 1 (line idle).
- Reset mid-frame abandons the partial word; nothing is pushed.
- rxd input: passes through a 2-flop synchroniser on clk; all decisions use the synchronised value rxs.
- en_rx=0: FSM and counters hold. FIFO pop and err_clr still operate.
- Sample counter:
  - Counts 0..OVERSAMPLE-1 on en_rx ticks.
  - Mid-bit point M = OVERSAMPLE/2.
  - Bit value is the majority of rxs captured at ticks M-1, M and M+1; the decision is taken at tick M+1.
- FSM states:
  - IDLE: on a tick with rxs=0, go to START and set counter to 1.
  - START: at the decision point, voted 1 means glitch, return to IDLE with no flags. Voted 0 means go to DATA at counter wrap.
  - DATA: bits are shifted in LSB first; after DATA_BITS bits go to PARITY if PARITY_EN=1, else to STOP.
  - PARITY: compute the voted bit XOR the data parity XOR PARITY_ODD; a nonzero result marks the word bad-parity.
  - STOP: voted 1 pushes the word and returns to IDLE. Voted 0 sets frame_err, pushes nothing, and goes to WAIT_IDLE.
  - WAIT_IDLE: on a tick with rxs=1, go to IDLE.
- Push timing: the push occurs on the clk edge of the stop-bit decision tick. rs and level update on that same edge.
- Bad-parity words are still pushed; parity_err is set on the same edge as the push.
- FIFO:
  - Circular buffer with read and write pointers one bit wider than the address.
  - d_out = mem[rd_ptr], combinational from registered storage.
  - rd while empty: ignored.
  - Push while full with no rd that cycle: word dropped, overrun set.
  - Push while full with rd in the same cycle: both happen, level unchanged, no overrun.
  - Push and pop together at any other level: level unchanged.
- Sticky flags: set has priority over err_clr in the same cycle.
- Widths: the data shift register is DATA_BITS wide; unused upper bits are not present.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - Default parameter constants.
  - A parity function: reduction XOR with an odd-parity select.
- One sub-module, uart_rx_fifo:
  - Parameters: width and depth.
  - Ports: push, pop, din, dout, level, full, empty.
  - Instantiated once inside uart_rx_param.

Test Plan:
1. Defaults, frame 0x55 sent at OVERSAMPLE=8 -> rs rises on the stop decision tick, d_out=0x55, level=1, all flags 0; rd -> rs=0.
2. rxd low for 2 ticks only, then high -> FSM returns to IDLE, no push, no flags. Single-tick glitch inside a data bit -> majority vote yields the correct byte 0xA3.
3. PARITY_EN=1, PARITY_ODD=0, data 0x07 with parity bit 0 -> word 0x07 pushed, parity_err=1. err_clr -> 0. Repeat with parity bit 1 -> parity_err stays 0.
4. Frame 0x3C with stop bit 0 -> no push, frame_err=1, FSM in WAIT_IDLE until rxd=1. Next valid frame 0x81 is received normally.
5. FIFO_DEPTH=4, five frames 0x01..0x05 with no rd -> level=4, overrun=1, reads return 0x01..0x04. Repeat with rd asserted on the 5th push cycle -> no overrun, 0x05 retained.
6. Assert rst mid-DATA of frame 0xFF -> all outputs reset immediately; after release, next frame 0x12 received correctly with no flags.
